// File: rtl/ram_access_seq.sv
// ram_access_seq: wait-stated read/write sequencer for an async SRAM; full clear sweep when RAM_CLEAR_EN is defined.
// Latency: rdValid WAIT_CYC+2 cycles after accept; write busy WAIT_CYC+2 cycles; clear (WAIT_CYC+2)*2^ADDR_W cycles.
// Backpressure: requests are held levels, taken once per assertion while idle; busy reports occupancy.
module ram_access_seq #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                WAIT_CYC  = 2,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              rRAM,
  input  logic              wRAM,
  input  logic              rstRAM,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              busy,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  output logic              clrDone,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [DATA_W-1:0] sramDout,
  input  logic [DATA_W-1:0] sramDin,
  output logic              sramCeN,
  output logic              sramOeN,
  output logic              sramWeN
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WREC, CLEAR, CREC} state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYC);

  state_t     state, nstate;
  logic [3:0] wcnt;
  logic       wlast, idle;
  logic       rd_arm, wr_arm;
  logic       clr_acc, wr_acc, rd_acc;

  assign idle  = (state == IDLE);
  assign wlast = (wcnt == WLAST);

`ifdef RAM_CLEAR_EN
  logic clr_arm;
  logic ptr_last;

  assign clr_acc  = idle && clr_arm && !rstRAM;
  assign ptr_last = &sramAddr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)        clr_arm <= 1'b1;
    else if (clr_acc) clr_arm <= 1'b0;
    else if (rstRAM)  clr_arm <= 1'b1;
  end
`else
  logic unused_rst_ram;
  assign unused_rst_ram = rstRAM;
  assign clr_acc        = 1'b0;
`endif

  // Clear outranks write, write outranks read; losers stay armed.
  assign wr_acc = idle && wr_arm && wRAM && !clr_acc;
  assign rd_acc = idle && rd_arm && rRAM && !clr_acc && !wr_acc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_arm <= 1'b1;
      wr_arm <= 1'b1;
    end else begin
      if (rd_acc)     rd_arm <= 1'b0;
      else if (!rRAM) rd_arm <= 1'b1;
      if (wr_acc)     wr_arm <= 1'b0;
      else if (!wRAM) wr_arm <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (clr_acc)     nstate = CLEAR;
        else if (wr_acc) nstate = WRITE;
        else if (rd_acc) nstate = READ;
      end
      READ:  if (wlast) nstate = IDLE;
      WRITE: if (wlast) nstate = WREC;
      WREC:  nstate = IDLE;
`ifdef RAM_CLEAR_EN
      CLEAR: if (wlast) nstate = CREC;
      CREC:  nstate = ptr_last ? IDLE : CLEAR;
`endif
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    sramCeN = 1'b1;
    sramOeN = 1'b1;
    sramWeN = 1'b1;
    busy    = 1'b0;
    clrDone = 1'b0;
    case (state)
      READ: begin
        sramCeN = 1'b0;
        sramOeN = 1'b0;
        busy    = 1'b1;
      end
      WRITE, CLEAR: begin
        sramCeN = 1'b0;
        sramWeN = 1'b0;
        busy    = 1'b1;
      end
      WREC, CREC: busy = 1'b1;
      default: ;
    endcase
`ifdef RAM_CLEAR_EN
    clrDone = (state == CREC) && ptr_last;
`endif
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wcnt <= 4'd0;
    end else if ((state == READ) || (state == WRITE) || (state == CLEAR)) begin
      wcnt <= wlast ? 4'd0 : wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

  // sramAddr doubles as the sweep pointer; it stays put through each recovery cycle for hold time.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sramAddr <= '0;
      sramDout <= '0;
      rdData   <= '0;
      rdValid  <= 1'b0;
    end else begin
      rdValid <= (state == READ) && wlast;
      if ((state == READ) && wlast) rdData <= sramDin;
      if (clr_acc) begin
        sramAddr <= '0;
        sramDout <= CLR_VALUE;
      end else if (wr_acc || rd_acc) begin
        sramAddr <= addrIn;
        sramDout <= dataIn;
      end
`ifdef RAM_CLEAR_EN
      else if ((state == CREC) && !ptr_last) begin
        sramAddr <= sramAddr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
`endif
    end
  end

endmodule

// File: tb/tb_ram_access_seq.sv
// Bench for ram_access_seq: cycle-accurate expectation queue built from the access rules, plus directed literal checks.
module tb_ram_access_seq;
  localparam int          AW   = 4;
  localparam int          DW   = 16;
  localparam int          W    = 2;
  localparam int          NW   = 1 << AW;
  localparam logic [15:0] CLRV = 16'h1111;
`ifdef RAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          rRAM = 1'b0, wRAM = 1'b0, rstRAM = 1'b1;
  logic [AW-1:0] addrIn = '0;
  logic [DW-1:0] dataIn = '0;
  logic          busy, rdValid, clrDone, sramCeN, sramOeN, sramWeN;
  logic [DW-1:0] rdData, sramDout, sramDin;
  logic [AW-1:0] sramAddr;

  always #5 clk = ~clk;

  ram_access_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W), .CLR_VALUE(CLRV)) dut (
    .clk(clk), .rstN(rstN), .rRAM(rRAM), .wRAM(wRAM), .rstRAM(rstRAM),
    .addrIn(addrIn), .dataIn(dataIn), .busy(busy), .rdValid(rdValid), .rdData(rdData),
    .clrDone(clrDone), .sramAddr(sramAddr), .sramDout(sramDout), .sramDin(sramDin),
    .sramCeN(sramCeN), .sramOeN(sramOeN), .sramWeN(sramWeN)
  );

  // Asynchronous SRAM: combinational read, write latched mid-cycle while CE and WE are low.
  logic [DW-1:0] sram_mem [NW];
  bit            sram_loaded = 1'b0;
  assign sramDin = sram_mem[sramAddr];
  always @(negedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= 16'h0101 * i[15:0];
      sram_loaded <= 1'b1;
    end else if (!sramCeN && !sramWeN) begin
      sram_mem[sramAddr] <= sramDout;
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // One record per clock cycle of expected pin behaviour.
  typedef struct {
    bit            bsy, ce, oe, we, rdv, cd;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
  } rec_t;

  function automatic rec_t mk(input bit bsy, input bit ce, input bit oe, input bit we,
                              input bit rdv, input bit cd, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] rd);
    rec_t r;
    r.bsy = bsy; r.ce = ce; r.oe = oe; r.we = we; r.rdv = rdv; r.cd = cd;
    r.a = a; r.d = d; r.rd = rd;
    return r;
  endfunction

  rec_t          q[$];
  logic [DW-1:0] model_mem [NW];
  bit            arm_r = 1, arm_w = 1, arm_c = 1;
  bit            e_busy = 0, e_ce = 1, e_oe = 1, e_we = 1, e_rdv = 0, e_cd = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_dout = '0, e_rdata = '0;

  always @(posedge clk or negedge rstN) begin : model
    rec_t r;
    if (!rstN) begin
      q.delete();
      arm_r = 1; arm_w = 1; arm_c = 1;
      e_busy = 0; e_ce = 1; e_oe = 1; e_we = 1; e_rdv = 0; e_cd = 0;
      e_addr = '0; e_dout = '0; e_rdata = '0;
    end else begin
      if (!e_busy) begin
        if (CLR_EN && arm_c && !rstRAM) begin
          arm_c = 0;
          for (int a = 0; a < NW; a++) begin
            for (int k = 0; k <= W; k++) q.push_back(mk(1, 0, 1, 0, 0, 0, AW'(a), CLRV, '0));
            q.push_back(mk(1, 1, 1, 1, 0, (a == NW - 1), AW'(a), CLRV, '0));
          end
        end else if (arm_w && wRAM) begin
          arm_w = 0;
          for (int k = 0; k <= W; k++) q.push_back(mk(1, 0, 1, 0, 0, 0, addrIn, dataIn, '0));
          q.push_back(mk(1, 1, 1, 1, 0, 0, addrIn, dataIn, '0));
        end else if (arm_r && rRAM) begin
          arm_r = 0;
          for (int k = 0; k <= W; k++) q.push_back(mk(1, 0, 0, 1, 0, 0, addrIn, dataIn, '0));
          q.push_back(mk(0, 1, 1, 1, 1, 0, addrIn, dataIn, model_mem[addrIn]));
        end
      end
      if (!rRAM)  arm_r = 1;
      if (!wRAM)  arm_w = 1;
      if (rstRAM) arm_c = 1;
      if (q.size() > 0) r = q.pop_front();
      else              r = mk(0, 1, 1, 1, 0, 0, e_addr, e_dout, '0);
      e_busy = r.bsy; e_ce = r.ce; e_oe = r.oe; e_we = r.we; e_rdv = r.rdv; e_cd = r.cd;
      e_addr = r.a; e_dout = r.d;
      if (r.rdv) e_rdata = r.rd;
    end
  end

  int  cnt_rdv = 0, cnt_busy = 0, cnt_cd = 0, cnt_oe = 0, cnt_we = 0;
  bit  model_loaded = 0;
  always @(negedge clk) begin : compare
    if (!model_loaded) begin
      for (int i = 0; i < NW; i++) model_mem[i] = 16'h0101 * i[15:0];
      model_loaded = 1;
    end else if (!e_ce && !e_we) begin
      model_mem[e_addr] = e_dout;
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("rdValid", 32'(rdValid), 32'(e_rdv));
    chk("rdData", 32'(rdData), 32'(e_rdata));
    chk("clrDone", 32'(clrDone), 32'(e_cd));
    chk("sramCeN", 32'(sramCeN), 32'(e_ce));
    chk("sramOeN", 32'(sramOeN), 32'(e_oe));
    chk("sramWeN", 32'(sramWeN), 32'(e_we));
    chk("sramAddr", 32'(sramAddr), 32'(e_addr));
    chk("sramDout", 32'(sramDout), 32'(e_dout));
    cnt_rdv  += int'(rdValid);
    cnt_busy += int'(busy);
    cnt_cd   += int'(clrDone);
    cnt_oe   += int'(!sramOeN);
    cnt_we   += int'(!sramWeN);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int b0, c0, r0, o0, w0;
    // Reset held with every request asserted.
    rRAM = 1; wRAM = 1; rstRAM = 0; addrIn = 4'h3; dataIn = 16'hBEEF;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({sramCeN, sramOeN, sramWeN}), 32'h7);
    chk("rst_rdData", 32'(rdData), 0);
    chk("rst_addr", 32'(sramAddr), 0);
    rstN = 1;
    tick(1);
    chk("t1_first_dout", 32'(sramDout), CLR_EN ? 32'h1111 : 32'hBEEF);
    chk("t1_first_we", 32'(sramWeN), 0);
    rstRAM = 1;
    tick(CLR_EN ? NW * (W + 2) + 20 : 20);
    rRAM = 0; wRAM = 0;
    tick(2);
    chk("t1_readback", 32'(rdData), 32'hBEEF);

    // Held read: one access, rdValid in the fourth cycle after accept.
    r0 = cnt_rdv; o0 = cnt_oe;
    rRAM = 1; addrIn = 4'h3;
    tick(3);
    chk("t2_rdv_early", 32'(rdValid), 0);
    addrIn = 4'h9;
    tick(1);
    chk("t2_rdv", 32'(rdValid), 1);
    chk("t2_data", 32'(rdData), 32'hBEEF);
    tick(16);
    rRAM = 0;
    tick(2);
    chk("t2_one_read", 32'(cnt_rdv - r0), 1);
    chk("t2_oe_cycles", 32'(cnt_oe - o0), 3);

    // Write, then drop and re-raise for a second write.
    b0 = cnt_busy; w0 = cnt_we;
    wRAM = 1; addrIn = 4'hF; dataIn = 16'h5A5A;
    tick(2);
    addrIn = 4'h1; dataIn = 16'h0000;
    tick(8);
    chk("t3_busy_cycles", 32'(cnt_busy - b0), 4);
    chk("t3_we_cycles", 32'(cnt_we - w0), 3);
    wRAM = 0;
    tick(2);
    addrIn = 4'hF; dataIn = 16'hC3C3; wRAM = 1;
    tick(8);
    wRAM = 0;
    chk("t3_rewrite", 32'(cnt_we - w0), 6);
    rRAM = 1;
    tick(6);
    rRAM = 0;
    tick(1);
    chk("t3_readback", 32'(rdData), 32'hC3C3);

    // Simultaneous write and read: write first, one idle cycle, then the read.
    addrIn = 4'h5; dataIn = 16'h1234; wRAM = 1; rRAM = 1;
    tick(5);
    chk("t5_gap_idle", 32'(busy), 0);
    tick(1);
    chk("t5_read_started", 32'(sramOeN), 0);
    tick(2);
    chk("t5_rdv_early", 32'(rdValid), 0);
    tick(1);
    chk("t5_rdv", 32'(rdValid), 1);
    chk("t5_data", 32'(rdData), 32'h1234);
    wRAM = 0; rRAM = 0;
    tick(3);

    // One-cycle clear pulse runs the whole sweep.
    b0 = cnt_busy; c0 = cnt_cd;
    rstRAM = 0;
    tick(1);
    rstRAM = 1;
    tick(NW * (W + 2) + 6);
    chk("t4_busy_cycles", 32'(cnt_busy - b0), CLR_EN ? 32'(NW * (W + 2)) : 0);
    chk("t4_clrdone", 32'(cnt_cd - c0), CLR_EN ? 1 : 0);
    for (int i = 0; i < NW; i++)
      chk("t4_mem", 32'(sram_mem[i]), CLR_EN ? 32'h1111 : 32'(model_mem[i]));

    // Randomised traffic, including occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 25) rRAM = ~rRAM;
      if ($urandom_range(99) < 25) wRAM = ~wRAM;
      rstRAM = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      addrIn = AW'($urandom);
      dataIn = DW'($urandom);
      rstN   = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rRAM = 0; wRAM = 0; rstRAM = 1; rstN = 1;
    tick(NW * (W + 2) + 10);

    // Reset in the third word of a sweep, then restart from address 0.
    c0 = cnt_cd;
    rstRAM = 0;
    tick(10);
    chk("t6_mid_addr", 32'(sramAddr), CLR_EN ? 2 : 32'(e_addr));
    rstN = 0;
    #1;
    chk("t6_rst_strobes", 32'({sramCeN, sramOeN, sramWeN}), 32'h7);
    chk("t6_rst_busy", 32'(busy), 0);
    tick(2);
    rstN = 1;
    tick(1);
    chk("t6_restart_addr", 32'(sramAddr), 0);
    chk("t6_restart_busy", 32'(busy), CLR_EN ? 1 : 0);
    tick(NW * (W + 2) + 4);
    chk("t6_clrdone", 32'(cnt_cd - c0), CLR_EN ? 1 : 0);
    rstRAM = 1;
    tick(3);
    for (int i = 0; i < NW; i++)
      chk("final_mem", 32'(sram_mem[i]), 32'(model_mem[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
